// File: rtl/sample_streamer.sv
// rtl/sample_streamer.sv - ping-pong sample buffer that replays each filled frame as a gapless stream
// Fill side writes one bank while the read FSM streams the other and holds it until the cell reports done.
module sample_streamer #(
  parameter int DATA_WIDTH   = 24,
  parameter int INPUT_LENGTH = 784
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_start,
  output logic                  m_active,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  cell_done,
  output logic [15:0]           frames_out
);

  localparam int AW = (INPUT_LENGTH > 1) ? $clog2(INPUT_LENGTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(INPUT_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    STREAM,
    WAIT_DONE
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] bank0_mem [INPUT_LENGTH];
  logic [DATA_WIDTH-1:0] bank1_mem [INPUT_LENGTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic          wr_bank_q, rd_bank_q;
  logic [AW-1:0] wr_addr_q;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [1:0]    full_q, full_d;
  logic [15:0]   frames_q;

  logic wr_fire, wr_last, rel;

  assign s_ready    = !rst && !full_q[wr_bank_q];
  assign wr_fire    = s_valid && s_ready;
  assign wr_last    = wr_fire && (wr_addr_q == LAST_ADDR);
  assign rel        = (state_q == WAIT_DONE) && cell_done;
  assign frames_out = frames_q;

  // Fill and release always target different banks, so both may update in one edge.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rel)     full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    m_active = 1'b0;
    m_start  = 1'b0;
    m_data   = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = PREFETCH;
      end
      PREFETCH: begin
        rd_en   = 1'b1;
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        m_active = 1'b1;
        m_start  = (cnt_q == '0);
        m_data   = rd_data_q;
        // Read one word ahead so the next cycle's sample is already registered.
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d   = cnt_q + AW'(1);
          rd_en   = 1'b1;
          rd_addr = cnt_q + AW'(1);
        end
      end
      WAIT_DONE: begin
        if (cell_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_addr_q <= '0;
      full_q    <= '0;
      frames_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      if (wr_fire) wr_addr_q <= wr_last ? '0 : wr_addr_q + AW'(1);
      if (wr_last) wr_bank_q <= !wr_bank_q;
      if (rel) begin
        rd_bank_q <= !rd_bank_q;
        frames_q  <= frames_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank_q) bank1_mem[wr_addr_q] <= s_data;
      else           bank0_mem[wr_addr_q] <= s_data;
    end
    if (rd_en) rd_data_q <= rd_bank_q ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
  end

endmodule

// File: tb/tb_sample_streamer.sv
// tb/tb_sample_streamer.sv - directed checks of sample_streamer with INPUT_LENGTH = 4
module tb_sample_streamer;
  localparam int DW = 24;
  localparam int L  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          cell_done = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, m_start, m_active;
  logic [DW-1:0] m_data;
  logic [15:0]   frames_out;

  sample_streamer #(.DATA_WIDTH(DW), .INPUT_LENGTH(L)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_start(m_start), .m_active(m_active), .m_data(m_data),
    .cell_done(cell_done), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [DW-1:0] data_q[$];
  int            start_q[$];
  int            idle_err = 0;

  // Record streamed samples and start cycles; outputs must be quiet outside a frame.
  always @(negedge clk) begin
    if (m_active) data_q.push_back(m_data);
    if (m_start) start_q.push_back(cyc_n);
    if (!m_active && (m_start || m_data != '0)) idle_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; cell_done = 1'b0; s_data = '0;
    next_cyc();
    next_cyc();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_active", m_active, 0);
    check("rst_m_start", m_start, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frames", frames_out, 0);
    rst = 1'b0;
    data_q.delete();
    start_q.delete();
    idle_err = 0;
  endtask

  task automatic send(input logic [DW-1:0] d, output int hc);
    int r;
    r = -1;
    s_valid = 1'b1;
    s_data = d;
    for (int k = 0; k < 50 && r < 0; k++) begin
      @(negedge clk);
      if (s_ready) r = cyc_n;
      next_cyc();
    end
    check($sformatf("hs_%0h", d), (r >= 0), 1);
    hc = r;
  endtask

  task automatic wait_starts(input int n);
    for (int k = 0; k < 100 && start_q.size() < n; k++) next_cyc();
    check($sformatf("start_seen_%0d", n), (start_q.size() >= n), 1);
  endtask

  task automatic wait_frame_end(input int n);
    for (int k = 0; k < 100 && !(data_q.size() >= n && !m_active); k++) next_cyc();
    check($sformatf("frame_end_%0d", n), (data_q.size() >= n && !m_active), 1);
  endtask

  task automatic pulse_done(output int d);
    cell_done = 1'b1;
    d = cyc_n;
    next_cyc();
    cell_done = 1'b0;
  endtask

  int h[8];
  int d, x, stall_bad;
  logic [DW-1:0] gv[4];

  initial begin
    // Single frame
    do_reset();
    for (int i = 0; i < 4; i++) send(DW'(i + 1), h[i]);
    s_valid = 1'b0;
    check("t1_hs_consecutive", h[3] - h[0], 3);
    wait_starts(1);
    check("t1_latency", start_q[0] - h[3], 3);
    wait_frame_end(4);
    check("t1_len", data_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_data%0d", i), data_q[i], i + 1);
    check("t1_frames_pre", frames_out, 0);
    pulse_done(d);
    check("t1_frames", frames_out, 1);
    check("t1_quiet", idle_err, 0);

    // Double buffering and stall of the ninth sample
    do_reset();
    for (int i = 0; i < 8; i++) send(DW'(i + 1), h[i]);
    check("t2_hs_consecutive", h[7] - h[0], 7);
    s_data = DW'(9);
    stall_bad = 0;
    for (int k = 0; k < 50 && !(data_q.size() >= 4 && !m_active); k++) begin
      if (s_ready) stall_bad++;
      next_cyc();
    end
    check("t2_stalled", stall_bad, 0);
    check("t2_stall_at_done", s_ready, 0);
    pulse_done(d);
    check("t2_ready_after_done", s_ready, 1);
    next_cyc();
    s_valid = 1'b0;
    wait_starts(2);
    check("t2_latency", start_q[1] - d, 3);
    wait_frame_end(8);
    for (int i = 0; i < 4; i++) check($sformatf("t2_data%0d", i + 4), data_q[i + 4], i + 5);
    check("t2_quiet", idle_err, 0);

    // Gapped input with garbage data between handshakes, then spurious done during stream
    do_reset();
    gv[0] = 24'h800000; gv[1] = 24'h7fffff; gv[2] = 24'h000001; gv[3] = 24'hfffffe;
    for (int i = 0; i < 4; i++) begin
      send(gv[i], h[i]);
      s_valid = 1'b0;
      s_data = 24'h5a5a5a;
      next_cyc();
    end
    check("t3_hs_gaps", h[3] - h[0], 6);
    wait_starts(1);
    cell_done = 1'b1;
    next_cyc();
    cell_done = 1'b0;
    wait_frame_end(4);
    check("t3_len", data_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t3_data%0d", i), data_q[i], gv[i]);
    repeat (3) next_cyc();
    check("t4_done_ignored", frames_out, 0);
    pulse_done(d);
    check("t4_frames", frames_out, 1);
    repeat (3) next_cyc();
    check("t4_single_inc", frames_out, 1);
    check("t3_quiet", idle_err, 0);

    // Reset in STREAM cycle 2
    do_reset();
    for (int i = 0; i < 4; i++) send(DW'(i + 1), h[i]);
    s_valid = 1'b0;
    wait_starts(1);
    next_cyc();
    rst = 1'b1;
    #1;
    check("t5_ready_in_rst", s_ready, 0);
    next_cyc();
    rst = 1'b0;
    #1;
    check("t5_active_after_rst", m_active, 0);
    check("t5_frames_after_rst", frames_out, 0);
    check("t5_ready_after_rst", s_ready, 1);
    data_q.delete();
    start_q.delete();
    for (int i = 0; i < 4; i++) send(DW'(i + 9), h[i]);
    s_valid = 1'b0;
    wait_starts(1);
    check("t5_latency", start_q[0] - h[3], 3);
    wait_frame_end(4);
    check("t5_len", data_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_data%0d", i), data_q[i], i + 9);

    // Bank 1 fill completes in the cell_done cycle of bank 0
    do_reset();
    for (int i = 0; i < 7; i++) send(DW'(i + 1), h[i]);
    s_valid = 1'b0;
    wait_frame_end(4);
    s_valid = 1'b1;
    s_data = DW'(8);
    cell_done = 1'b1;
    x = cyc_n;
    check("t6_ready_last_fill", s_ready, 1);
    next_cyc();
    s_valid = 1'b0;
    cell_done = 1'b0;
    check("t6_frames", frames_out, 1);
    check("t6_bank0_freed", s_ready, 1);
    wait_starts(2);
    check("t6_latency", start_q[1] - x, 3);
    wait_frame_end(8);
    for (int i = 0; i < 4; i++) check($sformatf("t6_data%0d", i + 4), data_q[i + 4], i + 5);
    pulse_done(d);
    check("t6_frames_2", frames_out, 2);
    check("t6_quiet", idle_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 24, sample word width in bits.
REQ-002 The block SHALL have parameter INPUT_LENGTH, default 784, samples per frame (INPUT_LENGTH >= 2).
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  block can accept an upstream sample.
REQ-007 s_data  input  DATA_WIDTH  upstream sample (two's-complement fixed point, passed through unmodified).
REQ-008 m_start  output  1  one-cycle pulse marking sample 0 of a frame on m_data.
REQ-009 m_active  output  1  high for exactly the INPUT_LENGTH cycles a frame is on m_data.
REQ-010 m_data  output  DATA_WIDTH  streamed sample, valid while m_active.
REQ-011 cell_done  input  1  completion pulse from the downstream linear cell(s) (their o_valid).
REQ-012 frames_out  output  16  count of frames released by cell_done.

Function
REQ-013 The block SHALL hold two sample banks (bank 0 and bank 1) of INPUT_LENGTH words each, with synchronous 1-cycle-latency reads, and a full flag per bank.
REQ-014 Fill side: s_ready SHALL equal NOT full[wr_bank]; a handshake (s_valid AND s_ready) SHALL write s_data to wr_bank at address wr_addr, then increment wr_addr.
REQ-015 On the handshake at wr_addr = INPUT_LENGTH-1: full[wr_bank] SHALL be set, wr_addr SHALL return to 0, and wr_bank SHALL toggle, all at the same edge.
REQ-016 s_valid while s_ready is low SHALL be ignored; s_data SHALL NOT be written.
REQ-017 The read-side FSM SHALL have states IDLE, PREFETCH, STREAM and WAIT_DONE.
REQ-018 IDLE -> PREFETCH SHALL occur when full[rd_bank] = 1; PREFETCH SHALL issue the read of address 0 and last exactly 1 cycle.
REQ-019 STREAM SHALL last exactly INPUT_LENGTH cycles, presenting bank word k on m_data in STREAM cycle k (k = 0..INPUT_LENGTH-1), with no gaps.
REQ-020 During STREAM, m_active SHALL be 1; m_start SHALL be 1 only in STREAM cycle 0.
REQ-021 After the last STREAM cycle, the FSM SHALL enter WAIT_DONE, with m_active = 0 and m_data = 0.
REQ-022 WAIT_DONE -> IDLE SHALL occur on cell_done = 1, at the same edge clearing full[rd_bank], toggling rd_bank and incrementing frames_out (wrap at 2^16).
REQ-023 cell_done SHALL be ignored in IDLE, PREFETCH and STREAM.
REQ-024 Latency: with the FSM in IDLE, m_start SHALL assert 3 cycles after the cycle of the final fill handshake (e.g. handshake in cycle c, m_start in cycle c+3).
REQ-025 Back-to-back: with the other bank full, m_start SHALL assert 3 cycles after the cell_done cycle.
REQ-026 Simultaneous fill completion on one bank and cell_done release of the other SHALL both take effect at the same edge.
REQ-027 While a bank streams or awaits done, filling of the other bank SHALL proceed unaffected; with both banks full, s_ready SHALL be 0.
REQ-028 Frame order SHALL be preserved: frames stream in fill order, alternating banks starting at bank 0.

Reset
REQ-029 While rst = 1 at an edge: FSM -> IDLE; wr_bank, rd_bank, wr_addr, full[1:0] and frames_out -> 0; m_start, m_active and m_data -> 0.
REQ-030 s_ready SHALL be 0 in any cycle where rst = 1.
REQ-031 Reset mid-fill or mid-stream SHALL abandon the partial frame; the first frame after reset SHALL begin at bank 0, address 0.
REQ-032 Bank memory contents SHALL NOT require reset.

Verification (INPUT_LENGTH = 4, DATA_WIDTH = 24)
REQ-033 Single frame: write 1, 2, 3, 4 on consecutive cycles from cycle 0 -> m_start in cycle 6; m_data = 1, 2, 3, 4 in cycles 6-9; m_active high in cycles 6-9 only; after cell_done, frames_out = 1.
REQ-034 Double buffering: write 8 samples continuously -> s_ready stays 1 through all 8 handshakes; the ninth sample is stalled (s_ready = 0) until cell_done; frame 2 (samples 5-8) m_start occurs 3 cycles after cell_done.
REQ-035 Backpressure and gaps: s_valid toggling 1/0 -> only handshake cycles write; stream order matches write order exactly.
REQ-036 Spurious done: pulse cell_done during STREAM -> ignored; FSM stays in WAIT_DONE until the next cell_done; frames_out increments once.
REQ-037 Reset mid-stream: assert rst in STREAM cycle 2 -> next cycle m_active = 0, s_ready = 1 after rst deasserts, frames_out = 0; new samples 9, 10, 11, 12 stream intact.
REQ-038 Simultaneous events: complete the bank 1 fill in the same cycle as cell_done for bank 0 -> both flags update correctly; bank 1 m_start follows 3 cycles later.
